cdc_event_rx: RTL
=================

# cdc_event_rx

Multi-channel, parametrised receiver for events launched from foreign clock domains. Each of N channels takes an asynchronous level (toggle or 4-phase request), synchronises it, detects events, and queues them in a saturating per-channel counter. A registered round-robin ready/valid port drains the events. It succeeds the single-channel two-domain pulse synchroniser as the receive-side endpoint, with queuing, overflow detection and two signalling modes.

## Interface
- N, 4: channel count, 1..32
- SYNC_STAGES, 2: synchroniser depth per channel, minimum 2
- CW, 4: pending-counter width; queue depth per channel is 2^CW-1
- MODE, EVT_TOGGLE: EVT_TOGGLE (event on any edge of the input) or EVT_HANDSHAKE (event on rising edge only, 4-phase)
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high; all state clears immediately
- evt_in  in  N  asynchronous channel levels from sender domains
- evt_ack  out  N  synchronised level of evt_in, returned to senders
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts event
- out_id  out  $clog2(N) (min 1)  channel of the presented event
- pending  out  N  per-channel counter nonzero
- error  out  N  sticky overflow flags
- err_clr  in  N  per-channel error clear

## Operation
- Per channel: a chain s[0..SYNC_STAGES-1] samples evt_in[i]. Register p holds the previous s[last].
  - EVT_TOGGLE: evt = s[last] ^ p.
  - EVT_HANDSHAKE: evt = s[last] & ~p.
- evt_ack[i] = s[last].
- Counter cnt[i] update:
  - evt and no consume: +1.
  - consume and no evt: -1.
  - Both in the same cycle: unchanged.
  - evt with cnt == 2^CW-1 and no consume: event dropped, cnt holds, error[i] set.
- error[i] clears on err_clr[i]. If set and clear occur in the same cycle, set wins.
- Output FSM, enum in the package:
  - IDLE: out_valid=0. If any pending, select the winner by searching from rr_ptr upward with wrap. Latch it into out_id and go to VALID.
  - VALID: out_valid=1; out_id is stable until the handshake.
  - On out_valid & out_ready: decrement cnt[out_id] and set rr_ptr = out_id+1 mod N.
  - After the handshake, search pending_next from out_id+1. pending_next is the pending vector with bit out_id cleared if cnt[out_id]==1.
  - If pending_next has a winner, stay in VALID with the new out_id (back-to-back); else go to IDLE.
- The presented event remains counted in cnt until its handshake, so pending[out_id] stays 1 while presented.
- Senders and this block are reset concurrently. An evt_in at 1 on reset release is taken as a real level change and produces an event.

## Timing
- Reset values: all sync, p, cnt, error = 0; rr_ptr=0; state IDLE; out_valid=0; out_id=0; evt_ack=0; pending=0.
- evt_in change setup to edge 1:
  - s[last] updates at edge SYNC_STAGES.
  - cnt = 1 and pending high at edge SYNC_STAGES+1.
  - out_valid high at edge SYNC_STAGES+2.
  - Latency is SYNC_STAGES+2 cycles (4 by default).
- Throughput: one event per cycle while out_ready stays high and events are pending.
- out_valid never drops without a handshake. Reset is the only exception.
- Asynchronous reset mid-transfer: out_valid drops immediately and queued events are lost. This is the only permitted event loss other than overflow.
- N=1: out_id is constant 0 and rr_ptr is unused.

## Structure
- Package cdc_event_pkg holds:
  - evt_mode_t (EVT_TOGGLE, EVT_HANDSHAKE)
  - out_state_t (IDLE, VALID)
  - the function computing round-robin first-set from a start index.
- Sub-module cdc_event_rx_chan contains one channel: sync chain, edge detect, saturating counter, error flag. It has ports for evt, consume, cnt, pending and error.
- Top level instantiates N channels plus the output FSM and arbiter.

## Test plan
- Toggle mode, N=4: toggle evt_in[2] 0→1 once -> out_valid at cycle 4, out_id=2, evt_ack[2]=1. Hold out_ready=1 -> one handshake, then pending=0.
- Handshake mode: raise evt_in[1], then drop it -> exactly one event. The fall produces no event; evt_ack[1] tracks evt_in[1] with 2-cycle delay.
- Fairness: channels 0, 1 and 3 each have one pending event and out_ready=1 throughout -> out_id sequence 0, 1, 3 back-to-back on consecutive cycles, then out_valid=0.
- Overflow, CW=2: 4 toggles on channel 0 with out_ready=0 -> cnt saturates at 3 and error[0]=1. Exactly 3 events drain. err_clr[0] clears the flag.
- Simultaneous: evt on channel 0 in the same cycle as the handshake of channel 0 at cnt=1 -> cnt stays 1 and out_valid stays high with out_id=0. Stall test: out_ready=0 for 10 cycles -> out_id is stable.
- Reset asserted while out_valid=1 -> all outputs are zero in the same cycle, without waiting for a clock edge. After release with evt_in=0, no events appear.

Source files
------------

// File: rtl/cdc_event_rx_pkg.sv
// Shared types and the round-robin search used by the cdc_event_rx block.
package cdc_event_pkg;

   typedef enum logic {EVT_TOGGLE, EVT_HANDSHAKE} evt_mode_t;
   typedef enum logic {IDLE, VALID} out_state_t;

   localparam int MAX_CH = 32;

   // First set bit of req at or after start, wrapping within n channels; 0 if none.
   function automatic int unsigned rr_first(input logic [MAX_CH-1:0] req,
                                            input int unsigned start,
                                            input int unsigned n);
      int unsigned idx;
      logic        found;
      rr_first = 0;
      found    = 1'b0;
      for (int unsigned k = 0; k < MAX_CH; k++) begin
         idx = start + k;
         if (idx >= n) idx = idx - n;
         if ((k < n) && !found && req[idx[4:0]]) begin
            rr_first = idx;
            found    = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/cdc_event_rx_if.sv
// Drain port of cdc_event_rx: valid/ready with the presented channel id.
interface cdc_event_rx_if #(parameter int N = 4);
   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   logic           out_valid;
   logic           out_ready;
   logic [IDW-1:0] out_id;

   modport master (output out_valid, output out_id, input out_ready);
   modport slave  (input out_valid, input out_id, output out_ready);
endinterface

// File: rtl/cdc_event_rx_chan.sv
// One receive channel: synchroniser, edge detect, saturating event counter, sticky overflow flag.
module cdc_event_rx_chan
   import cdc_event_pkg::*;
#(
   parameter int        SYNC_STAGES = 2,
   parameter int        CW          = 4,
   parameter evt_mode_t MODE        = EVT_TOGGLE
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          evt_i,
   input  logic          consume_i,
   input  logic          err_clr_i,
   output logic          ack_o,
   output logic          evt_o,
   output logic [CW-1:0] cnt_o,
   output logic          pending_o,
   output logic          error_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   p_q;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   err_q, err_d;
   logic                   s_last, evt, full;

   assign s_last = sync_q[SYNC_STAGES-1];
   assign evt    = (MODE == EVT_TOGGLE) ? (s_last ^ p_q) : (s_last & ~p_q);
   assign full   = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (evt && !consume_i && !full)
         cnt_d = cnt_q + CW'(1);
      else if (!evt && consume_i)
         cnt_d = cnt_q - CW'(1);
   end

   // A dropped event sets the flag; a set in the same cycle overrides the clear.
   assign err_d = (evt & ~consume_i & full) | (err_q & ~err_clr_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         p_q    <= 1'b0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], evt_i};
         p_q    <= s_last;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign ack_o     = s_last;
   assign evt_o     = evt;
   assign cnt_o     = cnt_q;
   assign pending_o = |cnt_q;
   assign error_o   = err_q;

endmodule

// File: rtl/cdc_event_rx.sv
// N-channel asynchronous event receiver with round-robin registered drain port.
module cdc_event_rx
   import cdc_event_pkg::*;
#(
   parameter int        N           = 4,
   parameter int        SYNC_STAGES = 2,
   parameter int        CW          = 4,
   parameter evt_mode_t MODE        = EVT_TOGGLE
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  evt_in,
   output logic [N-1:0]  evt_ack,
   output logic [N-1:0]  pending,
   output logic [N-1:0]  error,
   input  logic [N-1:0]  err_clr,
   cdc_event_rx_if.master out
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   out_state_t        state_q, state_d;
   logic [IDW-1:0]    id_q, id_d, rr_q, rr_d, next_id;
   logic [N-1:0]      consume, evt, pend_nxt;
   logic [CW-1:0]     cnt [N];
   logic [MAX_CH-1:0] req_now, req_nxt;
   logic              hs;

   assign hs = out.out_valid & out.out_ready;

   for (genvar i = 0; i < N; i++) begin : g_ch
      assign consume[i] = hs && (id_q == IDW'(i));
      // Pending after this cycle's update, including a simultaneous arrival.
      assign pend_nxt[i] = evt[i] | ((cnt[i] != '0) & ~(consume[i] & (cnt[i] == CW'(1))));

      cdc_event_rx_chan #(
         .SYNC_STAGES (SYNC_STAGES),
         .CW          (CW),
         .MODE        (MODE)
      ) u_chan (
         .clk       (clk),
         .rst       (reset),
         .evt_i     (evt_in[i]),
         .consume_i (consume[i]),
         .err_clr_i (err_clr[i]),
         .ack_o     (evt_ack[i]),
         .evt_o     (evt[i]),
         .cnt_o     (cnt[i]),
         .pending_o (pending[i]),
         .error_o   (error[i])
      );
   end

   assign req_now = MAX_CH'(pending);
   assign req_nxt = MAX_CH'(pend_nxt);
   assign next_id = (id_q == IDW'(N-1)) ? '0 : id_q + IDW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         id_q    <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      rr_d    = rr_q;
      case (state_q)
         IDLE: begin
            if (|pending) begin
               id_d    = IDW'(rr_first(req_now, 32'(rr_q), N));
               state_d = VALID;
            end
         end
         VALID: begin
            if (out.out_ready) begin
               rr_d = next_id;
               if (|pend_nxt)
                  id_d = IDW'(rr_first(req_nxt, 32'(next_id), N));
               else
                  state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out.out_valid = (state_q == VALID);
      out.out_id    = id_q;
   end

endmodule
